// File: rtl/pipe_stall_ctrl_if.sv
// Control-side bundle between the stall/flush controller and the pipeline
// transfer registers: busy/redirect requests in, stall/flush/redirect out.
interface pipe_stall_ctrl_if;
  logic       imem_busy;
  logic       dmem_busy;
  logic       x_br_taken;
  logic       stall;
  logic       flush_i;
  logic       pc_redirect;
  logic [1:0] busy_state;

  modport master (
    input  imem_busy,
    input  dmem_busy,
    input  x_br_taken,
    output stall,
    output flush_i,
    output pc_redirect,
    output busy_state
  );

  modport slave (
    output imem_busy,
    output dmem_busy,
    output x_br_taken,
    input  stall,
    input  flush_i,
    input  pc_redirect,
    input  busy_state
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the I->X and X->W transfer registers of the 3-stage core.
// Optional performance counters stall_cnt/flush_cnt are built when PIPE_PERF_EN is defined.
module pipe_stall_ctrl #(
  parameter int RESET_HOLD = 2
) (
  input  logic               clk,
  input  logic               reset,
  pipe_stall_ctrl_if.master  ctrl
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]        stall_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam logic [3:0] HOLD_INIT = 4'(RESET_HOLD - 1);

  state_e     state_q;
  logic [3:0] hold_q;
  logic       redirect_done_q;
  logic       redirect_done_d;
  logic       flush_pending_q;
  logic       flush_pending_d;
  logic       busy;
  logic       stall;
  logic       pc_redirect;
  logic       flush;

  assign busy        = ctrl.imem_busy | ctrl.dmem_busy;
  assign stall       = (state_q == BOOT) | busy;
  assign pc_redirect = ctrl.x_br_taken & ~redirect_done_q & (state_q != BOOT);
  assign flush       = pc_redirect | flush_pending_q;

  assign ctrl.stall       = stall;
  assign ctrl.flush_i     = flush;
  assign ctrl.pc_redirect = pc_redirect;
  assign ctrl.busy_state  = state_q;

  // A redirect issued while stalled is remembered until the first unstalled
  // cycle, so it fires only once and its NOP still reaches X.
  always_comb begin
    redirect_done_d = redirect_done_q;
    flush_pending_d = flush_pending_q;
    if (!stall) begin
      redirect_done_d = 1'b0;
      flush_pending_d = 1'b0;
    end else if (pc_redirect) begin
      redirect_done_d = 1'b1;
      flush_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
      hold_q  <= HOLD_INIT;
    end else begin
      case (state_q)
        BOOT: begin
          if (hold_q == 4'd0) begin
            state_q <= RUN;
          end else begin
            hold_q <= hold_q - 4'd1;
          end
        end
        RUN: begin
          if (busy) begin
            state_q <= STALL;
          end
        end
        STALL: begin
          if (!busy) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q <= BOOT;
          hold_q  <= HOLD_INIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_done_q <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      redirect_done_q <= redirect_done_d;
      flush_pending_q <= flush_pending_d;
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Boot-time stalls are excluded; a flush counts once its NOP is committed.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall && (state_q != BOOT)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush && !stall) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a cycle-history model checked every cycle
// plus hand-computed literal expectations for the key scenarios.
module tb_pipe_stall_ctrl;

  localparam int HOLD = 2;

  logic clk;
  logic reset;
  pipe_stall_ctrl_if bus ();

`ifdef PIPE_PERF_EN
  logic [31:0] stallCnt;
  logic [31:0] flushCnt;
`endif

  pipe_stall_ctrl #(.RESET_HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
`ifdef PIPE_PERF_EN
    ,
    .stall_cnt (stallCnt),
    .flush_cnt (flushCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Model: k counts cycles since the last cycle that sampled reset high.
  // Boot lasts HOLD cycles; a stalled redirect is "owed" until an unstalled cycle.
  bit          modelValid = 1'b0;
  int          k = 0;
  bit          prevBoot = 1'b1;
  bit          prevBusy = 1'b0;
  bit          redirectedThisStall = 1'b0;
  logic [31:0] stallCount = 32'd0;
  logic [31:0] flushCount = 32'd0;

  logic       mBoot;
  logic       mStall;
  logic       mRedirect;
  logic       mFlush;
  logic [1:0] mState;

  always @* begin
    mBoot     = (k < HOLD);
    mStall    = mBoot | bus.imem_busy | bus.dmem_busy;
    mRedirect = bus.x_br_taken & !mBoot & !redirectedThisStall;
    mFlush    = mRedirect | redirectedThisStall;
    if (mBoot)
      mState = 2'd0;
    else if (!prevBoot && prevBusy)
      mState = 2'd2;
    else
      mState = 2'd1;
  end

  always @(posedge clk) begin
    if (reset) begin
      modelValid          = 1'b1;
      k                   = 0;
      prevBoot            = 1'b1;
      prevBusy            = 1'b0;
      redirectedThisStall = 1'b0;
      stallCount          = 32'd0;
      flushCount          = 32'd0;
    end else if (modelValid) begin
      if (mStall && !mBoot) stallCount = stallCount + 32'd1;
      if (mFlush && !mStall) flushCount = flushCount + 32'd1;
      if (!mStall) redirectedThisStall = 1'b0;
      else if (mRedirect) redirectedThisStall = 1'b1;
      prevBoot = mBoot;
      prevBusy = bus.imem_busy | bus.dmem_busy;
      if (k < 1000) k++;
    end
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("model_stall", {31'd0, bus.stall}, {31'd0, mStall});
      checkOutput("model_flush_i", {31'd0, bus.flush_i}, {31'd0, mFlush});
      checkOutput("model_pc_redirect", {31'd0, bus.pc_redirect}, {31'd0, mRedirect});
      checkOutput("model_busy_state", {30'd0, bus.busy_state}, {30'd0, mState});
`ifdef PIPE_PERF_EN
      checkOutput("model_stall_cnt", stallCnt, stallCount);
      checkOutput("model_flush_cnt", flushCnt, flushCount);
`endif
    end
  end

  task automatic applyStimulus(input logic rst, input logic ib, input logic db, input logic br);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.imem_busy  = ib;
    bus.dmem_busy  = db;
    bus.x_br_taken = br;
    @(negedge clk);
    #1;
  endtask

  logic [2:0] vecs [16];
  logic [31:0] base;

  initial begin
    reset          = 1'b1;
    bus.imem_busy  = 1'b0;
    bus.dmem_busy  = 1'b0;
    bus.x_br_taken = 1'b0;
    base           = 32'd0;
    vecs = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b011, 3'b000, 3'b101, 3'b100,
             3'b001, 3'b000, 3'b111, 3'b001, 3'b001, 3'b000, 3'b110, 3'b000};

    // Reset state
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("reset_flush", {31'd0, bus.flush_i}, 32'd0);
    checkOutput("reset_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("reset_state", {30'd0, bus.busy_state}, 32'd0);

    // Boot hold: two stalled cycles, then RUN
    applyStimulus(0, 0, 0, 0);
    checkOutput("boot0_stall", {31'd0, bus.stall}, 32'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("boot1_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("boot1_state", {30'd0, bus.busy_state}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("run_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("run_state", {30'd0, bus.busy_state}, 32'd1);

    // dmem_busy for 3 cycles in RUN
`ifdef PIPE_PERF_EN
    base = stallCnt;
`endif
    applyStimulus(0, 0, 1, 0);
    checkOutput("dbusy1_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("dbusy1_state", {30'd0, bus.busy_state}, 32'd1);
    applyStimulus(0, 0, 1, 0);
    checkOutput("dbusy2_state", {30'd0, bus.busy_state}, 32'd2);
    applyStimulus(0, 0, 1, 0);
    checkOutput("dbusy3_state", {30'd0, bus.busy_state}, 32'd2);
    applyStimulus(0, 0, 0, 0);
    checkOutput("dbusy_end_stall", {31'd0, bus.stall}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("dbusy_after_state", {30'd0, bus.busy_state}, 32'd1);
`ifdef PIPE_PERF_EN
    checkOutput("dbusy_stall_cnt", stallCnt - base, 32'd3);
    base = flushCnt;
`endif

    // Single-cycle taken branch, no busy
    applyStimulus(0, 0, 0, 1);
    checkOutput("br1_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    checkOutput("br1_flush", {31'd0, bus.flush_i}, 32'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("br1_after_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("br1_after_flush", {31'd0, bus.flush_i}, 32'd0);
`ifdef PIPE_PERF_EN
    checkOutput("br1_flush_cnt", flushCnt - base, 32'd1);
    base = flushCnt;
`endif

    // Branch held across 3 imem stall cycles
    applyStimulus(0, 1, 0, 1);
    checkOutput("held1_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    checkOutput("held1_flush", {31'd0, bus.flush_i}, 32'd1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("held2_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("held2_flush", {31'd0, bus.flush_i}, 32'd1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("held3_flush", {31'd0, bus.flush_i}, 32'd1);
    applyStimulus(0, 0, 0, 1);
    checkOutput("held4_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("held4_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("held4_flush", {31'd0, bus.flush_i}, 32'd1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("held5_flush", {31'd0, bus.flush_i}, 32'd0);
`ifdef PIPE_PERF_EN
    checkOutput("held_flush_cnt", flushCnt - base, 32'd1);
`endif

    // Busy drops while a fresh branch arrives
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("new_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    checkOutput("new_flush", {31'd0, bus.flush_i}, 32'd1);
    applyStimulus(0, 0, 0, 0);

    // Reset during a stall with a pending flush
    applyStimulus(0, 0, 1, 1);
    checkOutput("rst_pre_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    applyStimulus(1, 0, 1, 1);
    checkOutput("rst_pending_flush", {31'd0, bus.flush_i}, 32'd1);
    applyStimulus(0, 0, 1, 1);
    checkOutput("rst_post_flush", {31'd0, bus.flush_i}, 32'd0);
    checkOutput("rst_post_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("rst_post_state", {30'd0, bus.busy_state}, 32'd0);
`ifdef PIPE_PERF_EN
    checkOutput("rst_post_stall_cnt", stallCnt, 32'd0);
    checkOutput("rst_post_flush_cnt", flushCnt, 32'd0);
`endif

    // Branch during BOOT is ignored
    applyStimulus(0, 0, 0, 1);
    checkOutput("boot_br_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("boot_br_flush", {31'd0, bus.flush_i}, 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("boot_done_stall", {31'd0, bus.stall}, 32'd0);

    // Mixed directed vectors {imem_busy, dmem_busy, x_br_taken}, model-checked
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, vecs[i][2], vecs[i][1], vecs[i][0]);
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
